uart_rx_top: RTL and testbench
==============================

Name: uart_rx_top

Overview:
- UART receive path for the peripheral: oversamples the serial input at the programmed baud divisor and assembles 8N1 frames, LSB first.
- Buffers received bytes in an internal 32-entry FIFO.
- Exposes data and status (full/empty/frame error/overrun) to the register block.
- Mirror of the transmit path: same baud_div semantics, same control/status register model.

Parameters:
- FIFO_AW, 5, FIFO address bits; depth = 2**FIFO_AW.
- SYNC_STAGES, 2, flip-flop stages on uart_rx_i before any use (min 2).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- UART_Kontrol_Yazmaci_rx_Active  in  1  receiver enable; 0 = ignore line.
- baud_div  in  16  clkfreq/baudrate, clocks per bit; valid range 4..65535.
- uart_rx_i  in  1  serial data in, idle high, asynchronous to clk_i.
- UART_Veri_Okuma_Yazmaci_enable  in  1  one-cycle read strobe; pops FIFO head.
- UART_Veri_Okuma_Yazmaci_rdata  out  8  FIFO head (first-word fall-through).
- UART_Durum_Yazmaci_rx_full  out  1  FIFO full.
- UART_Durum_Yazmaci_rx_empty  out  1  FIFO empty.
- UART_Durum_Yazmaci_rx_frame_err  out  1  sticky: stop bit sampled 0.
- UART_Durum_Yazmaci_rx_overrun  out  1  sticky: good byte dropped because FIFO full.
- UART_Durum_Yazmaci_err_clr  in  1  one-cycle strobe; clears both sticky flags.

Behaviour:
- Reset: rx_empty=1, rx_full=0, rdata=0x00, frame_err=0, overrun=0, FSM=S_IDLE, all synchroniser flops=1, FIFO pointers=0.
- Synchroniser: rx_s = uart_rx_i delayed SYNC_STAGES clocks; all decisions use rx_s.
- Bit timer: 16-bit counter; baud_div is latched into bd_q at start detection and held for the whole frame.
- FSM (one-hot):
  - S_IDLE: if rx_active and rx_s==0 (falling edge or line already low), latch baud_div, load timer with bd_q>>1, go to S_START.
  - S_START: at timer expiry (mid start bit), sample rx_s. If 0, go to S_DATA with bit index 0 and timer=bd_q. If 1 (glitch), go to S_IDLE with no side effects.
  - S_DATA: at each expiry, shift rx_s into bit[idx] (LSB first) and reload timer=bd_q. After idx 7, go to S_STOP.
  - S_STOP: at expiry, sample rx_s.
    - 1: push byte if not full, else set overrun and discard.
    - 0: set frame_err and discard byte.
    - Either way, go to S_IDLE.
    - S_IDLE must then see rx_s==1 at least once before accepting a new start (break line does not retrigger).
- rx_active deasserted in any state: abort frame on the next clock, return to S_IDLE, no push, no flags.
- FIFO:
  - Push is visible the cycle after the stop sample: rx_empty falls and rdata holds the byte.
  - Read strobe while empty is ignored.
  - Push and pop in the same cycle: both take effect, count unchanged, including when full.
  - Pointers wrap modulo depth; full/empty derive from an (FIFO_AW+1)-bit count.
- Sticky flags: set has priority over err_clr in the same cycle.
- Sample instant within bit n (n=0 start): start edge seen + bd_q>>1 + n*bd_q clocks (±1).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; FSM adds S_PARITY between S_DATA and S_STOP, sampled at bd_q.
  - Even parity of data+parity bit mismatch sets sticky output UART_Durum_Yazmaci_rx_parity_err (port exists only when defined, cleared by err_clr) and discards the byte.
  - Stop bit is still checked; frame_err takes precedence over parity_err.
- Undefined: 8N1 only; no S_PARITY state, no parity port.

Test Plan:
- baud_div=16, rx_active=1, send 0xA5 8N1 → rx_empty falls ≤2 clocks after stop mid-point. rdata=0xA5. One read strobe → rx_empty=1.
- Send 33 bytes 0x00..0x20 with no reads → rx_full=1 after byte 31. 0x20 dropped, overrun=1. Reads return 0x00..0x1F in order. err_clr → overrun=0.
- Send 0x3C with stop bit forced 0 → frame_err=1, FIFO stays empty. Next valid 0x55 → rdata=0x55, frame_err stays 1 until err_clr.
- Low pulse of 5 clocks at baud_div=16 → no byte, no flags, FSM back in S_IDLE. Deassert rx_active mid-byte → no push; the following full frame 0x81 is received correctly.
- FIFO full plus read strobe coincident with stop-bit push → count stays 32, no overrun, order preserved.
- UART_RX_PARITY_EN defined: 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → parity_err=1, no push.

Source files
------------

// File: rtl/uart_rx_top.sv
// UART receive path: synchroniser, oversampled 8N1 frame assembly, 32-entry FWFT FIFO, sticky errors.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose UART_Durum_Yazmaci_rx_parity_err.
module uart_rx_top #(
  parameter int FIFO_AW     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        UART_Kontrol_Yazmaci_rx_Active,
  input  logic [15:0] baud_div,
  input  logic        uart_rx_i,
  input  logic        UART_Veri_Okuma_Yazmaci_enable,
  output logic [7:0]  UART_Veri_Okuma_Yazmaci_rdata,
  output logic        UART_Durum_Yazmaci_rx_full,
  output logic        UART_Durum_Yazmaci_rx_empty,
  output logic        UART_Durum_Yazmaci_rx_frame_err,
  output logic        UART_Durum_Yazmaci_rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic        UART_Durum_Yazmaci_rx_parity_err,
`endif
  input  logic        UART_Durum_Yazmaci_err_clr
);

  localparam int DEPTH = 1 << FIFO_AW;

`ifdef UART_RX_PARITY_EN
  localparam int SW = 5;
  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_START  = 5'b00010;
  localparam logic [4:0] S_DATA   = 5'b00100;
  localparam logic [4:0] S_PARITY = 5'b01000;
  localparam logic [4:0] S_STOP   = 5'b10000;
`else
  localparam int SW = 4;
  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_START = 4'b0010;
  localparam logic [3:0] S_DATA  = 4'b0100;
  localparam logic [3:0] S_STOP  = 4'b1000;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [SW-1:0]          state;
  logic [15:0]            tmr;
  logic [15:0]            bd_q;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   par_q;
  logic                   armed;
  logic                   tick;
  logic                   start_det;
  logic                   stop_ev;
  logic                   good;
  logic                   par_bad;
  logic                   push;
  logic                   pop;
  logic [7:0]             mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr;
  logic [FIFO_AW-1:0]     rd_ptr;
  logic [FIFO_AW:0]       count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // A start is only accepted after the line has been seen high in idle, so a break does not retrigger.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) armed <= 1'b1;
    else         armed <= (state == S_IDLE) ? (armed | rx_s) : 1'b0;
  end

  assign tick      = (tmr <= 16'd1);
  assign start_det = UART_Kontrol_Yazmaci_rx_Active && (state == S_IDLE) && armed && !rx_s;
  assign stop_ev   = UART_Kontrol_Yazmaci_rx_Active && (state == S_STOP) && tick;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= S_IDLE;
      tmr     <= 16'd0;
      bd_q    <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      par_q   <= 1'b0;
    end else if (!UART_Kontrol_Yazmaci_rx_Active) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_det) begin
          bd_q  <= baud_div;
          tmr   <= {1'b0, baud_div[15:1]};
          state <= S_START;
        end
        S_START: if (tick) begin
          if (!rx_s) begin
            state   <= S_DATA;
            bit_idx <= 3'd0;
            tmr     <= bd_q;
          end else begin
            state <= S_IDLE;
          end
        end else tmr <= tmr - 16'd1;
        S_DATA: if (tick) begin
          shreg   <= {rx_s, shreg[7:1]};
          tmr     <= bd_q;
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= S_PARITY;
`else
          if (bit_idx == 3'd7) state <= S_STOP;
`endif
        end else tmr <= tmr - 16'd1;
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick) begin
          par_q <= rx_s;
          tmr   <= bd_q;
          state <= S_STOP;
        end else tmr <= tmr - 16'd1;
`endif
        S_STOP: if (tick) state <= S_IDLE;
                else      tmr   <= tmr - 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_bad = stop_ev && rx_s && (^{shreg, par_q});
`else
  assign par_bad = 1'b0;
`endif
  assign good = stop_ev && rx_s && !par_bad;
  assign pop  = UART_Veri_Okuma_Yazmaci_enable && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign push = good && (!UART_Durum_Yazmaci_rx_full || pop);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign UART_Durum_Yazmaci_rx_empty   = (count == '0);
  assign UART_Durum_Yazmaci_rx_full    = (count == (FIFO_AW+1)'(DEPTH));
  assign UART_Veri_Okuma_Yazmaci_rdata = UART_Durum_Yazmaci_rx_empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      UART_Durum_Yazmaci_rx_frame_err <= 1'b0;
      UART_Durum_Yazmaci_rx_overrun   <= 1'b0;
    end else begin
      if (stop_ev && !rx_s)                     UART_Durum_Yazmaci_rx_frame_err <= 1'b1;
      else if (UART_Durum_Yazmaci_err_clr)      UART_Durum_Yazmaci_rx_frame_err <= 1'b0;
      if (good && UART_Durum_Yazmaci_rx_full && !pop) UART_Durum_Yazmaci_rx_overrun <= 1'b1;
      else if (UART_Durum_Yazmaci_err_clr)      UART_Durum_Yazmaci_rx_overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                         UART_Durum_Yazmaci_rx_parity_err <= 1'b0;
    else if (par_bad)                    UART_Durum_Yazmaci_rx_parity_err <= 1'b1;
    else if (UART_Durum_Yazmaci_err_clr) UART_Durum_Yazmaci_rx_parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: serial frame driver, queue-based receive model, per-cycle compare, final report.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_top;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_active = 1'b0;
  logic [15:0] baud_div = 16'd16;
  logic        rx_line = 1'b1;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  rdata;
  logic        full, empty, fe, ov, pe;

  uart_rx_top dut (
    .clk_i                           (clk),
    .rstn_i                          (rstn),
    .UART_Kontrol_Yazmaci_rx_Active  (rx_active),
    .baud_div                        (baud_div),
    .uart_rx_i                       (rx_line),
    .UART_Veri_Okuma_Yazmaci_enable  (rd_en),
    .UART_Veri_Okuma_Yazmaci_rdata   (rdata),
    .UART_Durum_Yazmaci_rx_full      (full),
    .UART_Durum_Yazmaci_rx_empty     (empty),
    .UART_Durum_Yazmaci_rx_frame_err (fe),
    .UART_Durum_Yazmaci_rx_overrun   (ov),
`ifdef UART_RX_PARITY_EN
    .UART_Durum_Yazmaci_rx_parity_err(pe),
`endif
    .UART_Durum_Yazmaci_err_clr      (err_clr)
  );
`ifndef UART_RX_PARITY_EN
  assign pe = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  // model and scoreboard state
  logic [7:0] exp_q[$];
  bit         m_fe, m_ov, m_pe;
  bit         model_valid = 1'b0;
  bit         stop_phase = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("empty", empty, 32'(exp_q.size() == 0));
      check("full", full, 32'(exp_q.size() == DEPTH));
      if (exp_q.size() > 0) check("rdata", rdata, exp_q[0]);
      check("frame_err", fe, m_fe);
      check("overrun", ov, m_ov);
      check("parity_err", pe, m_pe);
    end
  end

  function automatic bit even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // driver tasks: entered and left just after a rising edge
  task automatic drive_bit(input logic b, input int bd);
    rx_line = b;
    repeat (bd) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int bd);
    model_valid = 1'b0;
    baud_div = 16'(bd);
    drive_bit(1'b0, bd);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bd);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b, bd);
`endif
    stop_phase = 1'b1;
    drive_bit(stop_b, bd);
    stop_phase = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (rx_active) begin
      if (!stop_b) m_fe = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (^{d, par_b}) m_pe = 1'b1;
`endif
      else if (exp_q.size() == DEPTH) m_ov = 1'b1;
      else exp_q.push_back(d);
    end
    model_valid = 1'b1;
  endtask

  task automatic read_byte(output logic [7:0] got, output logic [7:0] want);
    got  = rdata;
    want = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_pe = 1'b0;
  endtask

  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, want;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_rdata", rdata, 8'h00);
    check("reset_frame_err", fe, 0);
    check("reset_overrun", ov, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rx_active = 1'b1;
    model_valid = 1'b1;

    // single byte and push latency
    fork
      send_frame(8'hA5, 1'b1, even_par(8'hA5), 16);
      begin
        wait (stop_phase == 1'b1);
        cnt = 0;
        while (empty && cnt < 40) begin
          @(negedge clk);
          cnt++;
        end
        check("push_latency_ok", 32'(cnt >= 9 && cnt <= 13), 1);
      end
    join
    check("a5_rdata", rdata, 8'hA5);
    read_byte(got, want);
    check("a5_read", got, 8'hA5);
    check("a5_empty_after_read", empty, 1);

    // fill to full, then overrun
    for (int i = 0; i < 33; i++) begin
      send_frame(8'(i), 1'b1, even_par(8'(i)), 16);
      if (i == 31) check("full_after_32", full, 1);
    end
    check("overrun_set", ov, 1);
    for (int i = 0; i < 32; i++) begin
      read_byte(got, want);
      check("drain_order", got, 32'(i));
    end
    clear_errs();
    check("overrun_cleared", ov, 0);

    // framing error, then a good byte with the sticky flag still set
    send_frame(8'h3C, 1'b0, even_par(8'h3C), 16);
    check("frame_err_set", fe, 1);
    check("frame_err_empty", empty, 1);
    send_frame(8'h55, 1'b1, even_par(8'h55), 16);
    check("after_fe_rdata", rdata, 8'h55);
    check("frame_err_sticky", fe, 1);
    read_byte(got, want);
    clear_errs();

    // short glitch is ignored
    baud_div = 16'd16;
    rx_line = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_byte", empty, 1);

    // abort mid-byte by dropping rx_active, then a clean frame
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    rx_active = 1'b0;
    rx_line = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    rx_active = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_push", empty, 1);
    send_frame(8'h81, 1'b1, even_par(8'h81), 16);
    read_byte(got, want);
    check("after_abort_81", got, 8'h81);

    // full FIFO with a read strobe coincident with the stop-bit push
    for (int i = 0; i < 32; i++) begin
      got = 8'($urandom_range(0, 255));
      send_frame(got, 1'b1, even_par(got), 16);
    end
    fork
      send_frame(8'hE7, 1'b1, even_par(8'hE7), 16);
      begin
        repeat (2 + 8 + 9 * 16) @(posedge clk);
        #1;
        read_byte(got, want);
        check("coincident_pop_head", got, want);
      end
    join
    check("coincident_full", full, 1);
    check("coincident_no_overrun", ov, 0);
    while (exp_q.size() > 0) begin
      read_byte(got, want);
      check("coincident_drain", got, want);
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 16);
    check("par_ok_rdata", rdata, 8'h07);
    read_byte(got, want);
    send_frame(8'h07, 1'b1, 1'b0, 16);
    check("par_err_set", pe, 1);
    check("par_err_no_push", empty, 1);
    clear_errs();
`endif

    // randomized frames against the model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] d;
      logic sb, pb;
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 7) != 0);
      pb = even_par(d) ^ ($urandom_range(0, 7) == 0);
      send_frame(d, sb, pb, $urandom_range(6, 24));
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) begin
        read_byte(got, want);
        check("rand_read", got, want);
      end
      if ($urandom_range(0, 9) == 0) clear_errs();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    while (exp_q.size() > 0) begin
      read_byte(got, want);
      check("rand_drain", got, want);
    end

    repeat (4) @(posedge clk);
    #1;
    model_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
